// File: rtl/divider_pkg.sv
// Shared types and constants for the sequential restoring divider.
// Holds the FSM state encoding and the default operand width.
package divider_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/divider_step.sv
// One restoring-division iteration: shift in the next dividend bit,
// trial-subtract the divisor, keep or restore, emit one quotient bit.
module divider_step
    import divider_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic [WIDTH-1:0] dvd_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_out,
    output logic [WIDTH-1:0] dvd_out
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;
    logic           fits;

    // rem_in < divisor, so the MSB of the WIDTH+1-bit difference is its sign
    assign shifted = {rem_in, dvd_in[WIDTH-1]};
    assign trial   = shifted - {1'b0, divisor};
    assign fits    = ~trial[WIDTH];

    assign rem_out = fits ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
    assign dvd_out = {dvd_in[WIDTH-2:0], fits};

endmodule

// File: rtl/sequential_divider.sv
// Multi-cycle unsigned restoring divider, one quotient bit per clock.
// Divide-by-zero short-circuits straight to DONE with a flagged result.
module sequential_divider
    import divider_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Start,
    input  logic [WIDTH-1:0] Dividend,
    input  logic [WIDTH-1:0] Divisor,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Quotient,
    output logic [WIDTH-1:0] Remainder,
    output logic             DivByZero
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t state;
    state_t state_next;

    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] dvd_q;
    logic [WIDTH-1:0] div_q;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] quo_r;
    logic [WIDTH-1:0] rem_r;
    logic             dbz_r;

    logic [WIDTH-1:0] rem_nxt;
    logic [WIDTH-1:0] dvd_nxt;

    logic accept;
    logic zero_div;
    logic last_step;

    divider_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .rem_in (rem_q),
        .dvd_in (dvd_q),
        .divisor(div_q),
        .rem_out(rem_nxt),
        .dvd_out(dvd_nxt)
    );

    assign zero_div  = (Divisor == '0);
    assign accept    = Start && (state != CALC);
    assign last_step = (state == CALC) && (count == LAST);

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (Start) begin
                    state_next = zero_div ? DONE : CALC;
                end
            end
            CALC: begin
                if (count == LAST) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (Start) begin
                    state_next = zero_div ? DONE : CALC;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            rem_q <= '0;
            dvd_q <= '0;
            div_q <= '0;
            count <= '0;
            quo_r <= '0;
            rem_r <= '0;
            dbz_r <= 1'b0;
        end else if (accept) begin
            rem_q <= '0;
            dvd_q <= Dividend;
            div_q <= Divisor;
            count <= '0;
            dbz_r <= zero_div;
            if (zero_div) begin
                quo_r <= '1;
                rem_r <= Dividend;
            end
        end else if (state == CALC) begin
            rem_q <= rem_nxt;
            dvd_q <= dvd_nxt;
            count <= count + CW'(1);
            // dividend register has become the quotient by the final step
            if (last_step) begin
                quo_r <= dvd_nxt;
                rem_r <= rem_nxt;
            end
        end
    end

    assign Busy      = (state == CALC);
    assign Done      = (state == DONE);
    assign Quotient  = quo_r;
    assign Remainder = rem_r;
    assign DivByZero = dbz_r;

endmodule

// File: tb/tb_sequential_divider.sv
// Self-checking bench for sequential_divider at WIDTH 4 and WIDTH 8.
// Results are compared against plain integer division in the bench.
module tb_sequential_divider;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset4, start4;
    logic [3:0] dividend4, divisor4;
    logic       busy4, done4, dbz4;
    logic [3:0] quo4, rem4;

    logic       reset8, start8;
    logic [7:0] dividend8, divisor8;
    logic       busy8, done8, dbz8;
    logic [7:0] quo8, rem8;

    int checks = 0;
    int errors = 0;

    sequential_divider #(.WIDTH(4)) dut4 (
        .Clock    (clk),
        .Reset    (reset4),
        .Start    (start4),
        .Dividend (dividend4),
        .Divisor  (divisor4),
        .Busy     (busy4),
        .Done     (done4),
        .Quotient (quo4),
        .Remainder(rem4),
        .DivByZero(dbz4)
    );

    sequential_divider #(.WIDTH(8)) dut8 (
        .Clock    (clk),
        .Reset    (reset8),
        .Start    (start8),
        .Dividend (dividend8),
        .Divisor  (divisor8),
        .Busy     (busy8),
        .Done     (done8),
        .Quotient (quo8),
        .Remainder(rem8),
        .DivByZero(dbz8)
    );

    // Start is presented for exactly one rising edge.
    task automatic issue4(input logic [3:0] a, input logic [3:0] b);
        dividend4 = a;
        divisor4  = b;
        start4    = 1'b1;
        @(posedge clk);
        #1 start4 = 1'b0;
    endtask

    task automatic issue8(input logic [7:0] a, input logic [7:0] b);
        dividend8 = a;
        divisor8  = b;
        start8    = 1'b1;
        @(posedge clk);
        #1 start8 = 1'b0;
    endtask

    // Edge 1 is the Start edge; returns the edge after which Done is seen.
    task automatic wait4(output int edges, output int busy_cnt);
        edges    = 1;
        busy_cnt = 0;
        @(negedge clk);
        while (!done4 && edges < 60) begin
            if (busy4) busy_cnt++;
            @(negedge clk);
            edges++;
        end
    endtask

    task automatic wait8(output int edges, output int busy_cnt);
        edges    = 1;
        busy_cnt = 0;
        @(negedge clk);
        while (!done8 && edges < 60) begin
            if (busy8) busy_cnt++;
            @(negedge clk);
            edges++;
        end
    endtask

    task automatic test_reset;
        reset4 = 1'b1; reset8 = 1'b1;
        start4 = 1'b1; start8 = 1'b1;
        dividend4 = 4'd9;  divisor4 = 4'd0;
        dividend8 = 8'd77; divisor8 = 8'd3;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({busy4, done4, dbz4, quo4, rem4} !== 11'd0) begin
            errors++;
            $display("FAIL reset4 got b%0b d%0b z%0b q%0d r%0d want all 0",
                     busy4, done4, dbz4, quo4, rem4);
        end
        checks++;
        if ({busy8, done8, dbz8, quo8, rem8} !== 19'd0) begin
            errors++;
            $display("FAIL reset8 got b%0b d%0b z%0b q%0d r%0d want all 0",
                     busy8, done8, dbz8, quo8, rem8);
        end
        start4 = 1'b0; start8 = 1'b0;
        reset4 = 1'b0; reset8 = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic;
        int e, bc;
        issue4(4'd13, 4'd3);
        wait4(e, bc);
        checks++;
        if (e !== 5) begin
            errors++;
            $display("FAIL basic_done_edge got %0d want 5", e);
        end
        checks++;
        if (bc !== 4) begin
            errors++;
            $display("FAIL basic_busy_cycles got %0d want 4", bc);
        end
        checks++;
        if ({quo4, rem4, dbz4} !== {4'd4, 4'd1, 1'b0}) begin
            errors++;
            $display("FAIL basic_result got q%0d r%0d z%0b want q4 r1 z0",
                     quo4, rem4, dbz4);
        end
        repeat (3) @(negedge clk);
        checks++;
        if ({done4, busy4, quo4, rem4} !== {1'b0, 1'b0, 4'd4, 4'd1}) begin
            errors++;
            $display("FAIL basic_hold got d%0b b%0b q%0d r%0d want d0 b0 q4 r1",
                     done4, busy4, quo4, rem4);
        end
    endtask

    task automatic test_div_zero;
        int e, bc;
        issue4(4'd9, 4'd0);
        wait4(e, bc);
        checks++;
        if (e !== 1 || bc !== 0) begin
            errors++;
            $display("FAIL dz_timing got edge %0d busy %0d want edge 1 busy 0",
                     e, bc);
        end
        checks++;
        if ({quo4, rem4, dbz4} !== {4'd15, 4'd9, 1'b1}) begin
            errors++;
            $display("FAIL dz_result got q%0d r%0d z%0b want q15 r9 z1",
                     quo4, rem4, dbz4);
        end
        @(negedge clk);
        issue4(4'd6, 4'd2);
        @(negedge clk);
        checks++;
        if (dbz4 !== 1'b0 || busy4 !== 1'b1) begin
            errors++;
            $display("FAIL dz_clear got z%0b b%0b want z0 b1", dbz4, busy4);
        end
        wait4(e, bc);
        @(negedge clk);
    endtask

    task automatic test_ignore_start;
        int e, bc;
        issue4(4'd15, 4'd8);
        @(negedge clk);
        @(negedge clk);
        issue4(4'd12, 4'd7);
        wait4(e, bc);
        checks++;
        if (e !== 3) begin
            errors++;
            $display("FAIL ignore_edge got %0d want 3", e);
        end
        checks++;
        if ({quo4, rem4, dbz4} !== {4'd1, 4'd7, 1'b0}) begin
            errors++;
            $display("FAIL ignore_result got q%0d r%0d z%0b want q1 r7 z0",
                     quo4, rem4, dbz4);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        int e, bc, dones;
        issue4(4'd14, 4'd5);
        @(negedge clk);
        @(negedge clk);
        reset4 = 1'b1;
        @(posedge clk);
        #1 reset4 = 1'b0;
        @(negedge clk);
        checks++;
        if ({busy4, done4, dbz4, quo4, rem4} !== 11'd0) begin
            errors++;
            $display("FAIL midreset got b%0b d%0b z%0b q%0d r%0d want all 0",
                     busy4, done4, dbz4, quo4, rem4);
        end
        dones = 0;
        repeat (6) begin
            @(negedge clk);
            if (done4) dones++;
        end
        checks++;
        if (dones !== 0) begin
            errors++;
            $display("FAIL midreset_nodone got %0d pulses want 0", dones);
        end
        issue4(4'd9, 4'd2);
        wait4(e, bc);
        checks++;
        if ({quo4, rem4} !== {4'd4, 4'd1} || e !== 5) begin
            errors++;
            $display("FAIL midreset_after got q%0d r%0d edge %0d want q4 r1 edge 5",
                     quo4, rem4, e);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        int e, bc;
        issue8(8'd255, 8'd16);
        wait8(e, bc);
        checks++;
        if ({quo8, rem8, dbz8} !== {8'd15, 8'd15, 1'b0} || e !== 9) begin
            errors++;
            $display("FAIL b2b_first got q%0d r%0d z%0b edge %0d want q15 r15 z0 edge 9",
                     quo8, rem8, dbz8, e);
        end
        issue8(8'd200, 8'd7);
        @(negedge clk);
        checks++;
        if (busy8 !== 1'b1 || done8 !== 1'b0) begin
            errors++;
            $display("FAIL b2b_calc got b%0b d%0b want b1 d0", busy8, done8);
        end
        wait8(e, bc);
        e = e + 1;
        checks++;
        if ({quo8, rem8, dbz8} !== {8'd28, 8'd4, 1'b0} || e !== 9) begin
            errors++;
            $display("FAIL b2b_second got q%0d r%0d z%0b edge %0d want q28 r4 z0 edge 9",
                     quo8, rem8, dbz8, e);
        end
        @(negedge clk);
    endtask

    task automatic test_exhaustive4;
        int e, bc, eq, er, ee;
        logic ez;
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                issue4(4'(a), 4'(b));
                wait4(e, bc);
                eq = (b == 0) ? 15 : a / b;
                er = (b == 0) ? a : a % b;
                ez = (b == 0);
                ee = (b == 0) ? 1 : 5;
                checks++;
                if (int'(quo4) !== eq || int'(rem4) !== er ||
                    dbz4 !== ez || e !== ee) begin
                    errors++;
                    $display("FAIL exh4 %0d/%0d got q%0d r%0d z%0b edge %0d want q%0d r%0d z%0b edge %0d",
                             a, b, quo4, rem4, dbz4, e, eq, er, ez, ee);
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic test_random8;
        int e, bc, a, b, eq, er, ee;
        logic ez;
        for (int n = 0; n < 200; n++) begin
            a = int'($urandom_range(0, 255));
            b = ($urandom_range(0, 15) == 0) ? 0 : int'($urandom_range(0, 255));
            issue8(8'(a), 8'(b));
            wait8(e, bc);
            eq = (b == 0) ? 255 : a / b;
            er = (b == 0) ? a : a % b;
            ez = (b == 0);
            ee = (b == 0) ? 1 : 9;
            checks++;
            if (int'(quo8) !== eq || int'(rem8) !== er ||
                dbz8 !== ez || e !== ee) begin
                errors++;
                $display("FAIL rnd8 %0d/%0d got q%0d r%0d z%0b edge %0d want q%0d r%0d z%0b edge %0d",
                         a, b, quo8, rem8, dbz8, e, eq, er, ez, ee);
            end
            if ($urandom_range(0, 1) == 1) @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_div_zero();
        test_ignore_start();
        test_reset_mid();
        test_back_to_back();
        test_exhaustive4();
        test_random8();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
